imem_loader: RTL and testbench

Parametrised instruction memory for the single-cycle RISC-V core with a byte-serial program-load port and a registered, fault-reporting fetch port. The fetch path takes the PC byte address and returns a little-endian 32-bit instruction one cycle later. The load path lets a host (UART bridge, testbench) stream the program image in without re-synthesis. An IDLE/LOAD/RUN state machine arbitrates between the two paths.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 87 ++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Program-load and instruction-fetch bus between a host/core (master) and imem_loader (slave).
interface imem_loader_if;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        load_trunc;
  logic        busy;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, load_done, load_trunc, busy,
    input  fetch_valid, instruction, fetch_fault, fault_cause
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, load_done, load_trunc, busy,
    output fetch_valid, instruction, fetch_fault, fault_cause
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-loadable instruction memory with a registered, fault-reporting 32-bit fetch port.
module imem_loader #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int unsigned AW             = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_WORD_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [AW-1:0] LAST_BYTE    = AW'(DEPTH_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [7:0]    mem [DEPTH_BYTES];
  logic          accept;
  logic [AW-1:0] faddr;

  always_comb begin
    accept = (state == LOAD) && bus.load_valid && !bus.load_start;
    faddr  = bus.fetch_addr[AW-1:0];
  end

  // Storage has no reset so it survives rst; writes are gated by the LOAD state.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= bus.load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wptr            <= '0;
      bus.load_ready  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.load_done   <= 1'b0;
      bus.load_trunc  <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.instruction <= NOP_WORD;
      bus.fetch_fault <= 1'b0;
      bus.fault_cause <= 2'b00;
    end else begin
      bus.load_done <= 1'b0;
      if (bus.load_start) begin
        state          <= LOAD;
        wptr           <= '0;
        bus.load_trunc <= 1'b0;
        bus.load_ready <= 1'b1;
        bus.busy       <= 1'b1;
      end else if (accept) begin
        wptr <= wptr + 1'b1;
        if (bus.load_last || wptr == LAST_BYTE) begin
          state          <= RUN;
          bus.load_ready <= 1'b0;
          bus.busy       <= 1'b0;
          bus.load_done  <= 1'b1;
          bus.load_trunc <= !bus.load_last;
        end
      end

      // Fetch sees the pre-edge state, so a coincident load_start still serves this request.
      bus.fetch_valid <= bus.fetch_req;
      if (bus.fetch_req) begin
        if (state != RUN) begin
          bus.instruction <= NOP_WORD;
          bus.fetch_fault <= 1'b1;
          bus.fault_cause <= 2'b11;
        end else if (bus.fetch_addr[1:0] != 2'b00) begin
          bus.instruction <= NOP_WORD;
          bus.fetch_fault <= 1'b1;
          bus.fault_cause <= 2'b01;
        end else if (bus.fetch_addr > LAST_WORD_ADDR) begin
          bus.instruction <= NOP_WORD;
          bus.fetch_fault <= 1'b1;
          bus.fault_cause <= 2'b10;
        end else begin
          bus.instruction <= {mem[faddr + AW'(3)], mem[faddr + AW'(2)],
                              mem[faddr + AW'(1)], mem[faddr]};
          bus.fetch_fault <= 1'b0;
          bus.fault_cause <= 2'b00;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: per-cycle comparison against a behavioural model plus literal checks.
module tb_imem_loader;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_BYTES(DEPTH), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a program image plus "loading"/"running" flags.
  logic [7:0]  m_mem [DEPTH];
  bit          m_loading = 0, m_running = 0;
  int          m_wptr = 0;
  logic        e_ready = 0, e_busy = 0, e_done = 0, e_trunc = 0, e_fv = 0, e_fault = 0;
  logic [1:0]  e_cause = 0;
  logic [31:0] e_instr = NOP;

  task automatic model_respond(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    e_instr = NOP;
    e_fault = 1;
    if (!m_running)        e_cause = 3;
    else if (a % 4 != 0)   e_cause = 1;
    else if (a > DEPTH - 4) e_cause = 2;
    else begin
      for (int k = 0; k < 4; k++) e_instr[8*k +: 8] = m_mem[int'(a) + k];
      e_fault = 0;
      e_cause = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_loading = 0; m_running = 0; m_wptr = 0;
      e_ready = 0; e_busy = 0; e_done = 0; e_trunc = 0;
      e_fv = 0; e_instr = NOP; e_fault = 0; e_cause = 0;
    end else begin
      e_done = 0;
      e_fv   = bus.fetch_req;
      if (bus.fetch_req) model_respond(bus.fetch_addr);
      if (bus.load_start) begin
        m_loading = 1; m_running = 0; m_wptr = 0; e_trunc = 0;
      end else if (m_loading && bus.load_valid) begin
        m_mem[m_wptr] = bus.load_data;
        if (bus.load_last || m_wptr == DEPTH - 1) begin
          m_loading = 0; m_running = 1; e_done = 1;
          e_trunc = !bus.load_last;
        end
        m_wptr++;
      end
      e_ready = m_loading;
      e_busy  = m_loading;
    end
  end

  initial forever begin
    @(negedge clk);
    check("load_ready", bus.load_ready, e_ready);
    check("busy", bus.busy, e_busy);
    check("load_done", bus.load_done, e_done);
    check("load_trunc", bus.load_trunc, e_trunc);
    check("fetch_valid", bus.fetch_valid, e_fv);
    check("fetch_fault", bus.fetch_fault, e_fault);
    check("fault_cause", bus.fault_cause, e_cause);
    if (!$isunknown(e_instr)) check("instruction", bus.instruction, e_instr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    cyc();
  endtask

  logic [7:0]  prog [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h37, 8'h01, 8'h00, 8'h10};
  logic [31:0] f_addr  [5] = '{32'h2, 32'h400, 32'h3FC, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
  logic [1:0]  f_cause [5] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

  initial begin
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
    bus.fetch_req = 0; bus.fetch_addr = 0;
    #12 rst = 1'b0;
    #1;
    check("reset instruction", bus.instruction, NOP);
    check("reset fetch_valid", bus.fetch_valid, 0);
    check("reset load_ready", bus.load_ready, 0);
    check("reset fault_cause", bus.fault_cause, 0);

    // Fetch in IDLE
    bus.fetch_req = 1; bus.fetch_addr = 0;
    cyc();
    check("idle fetch valid", bus.fetch_valid, 1);
    check("idle fetch instr", bus.instruction, NOP);
    check("idle fetch cause", bus.fault_cause, 2'b11);
    bus.fetch_req = 0;

    // Short program, with a fetch coinciding with the completing byte
    bus.load_start = 1; cyc(); bus.load_start = 0;
    check("load busy", bus.busy, 1);
    for (int i = 0; i < 7; i++) send(prog[i], 1'b0);
    bus.fetch_req = 1; bus.fetch_addr = 0;
    send(prog[7], 1'b1);
    bus.load_valid = 0; bus.load_last = 0;
    check("done pulse", bus.load_done, 1);
    check("same-cycle fetch cause", bus.fault_cause, 2'b11);
    cyc();
    check("done single", bus.load_done, 0);
    check("word0", bus.instruction, 32'h0050_0093);
    check("word0 cause", bus.fault_cause, 2'b00);
    bus.fetch_addr = 4; cyc();
    check("word1", bus.instruction, 32'h1000_0137);
    for (int i = 0; i < 5; i++) begin
      bus.fetch_addr = f_addr[i]; cyc();
      check("edge cause", bus.fault_cause, f_cause[i]);
      check("edge fault", bus.fetch_fault, (f_cause[i] != 2'b00));
      if (f_cause[i] != 2'b00) check("edge nop", bus.instruction, NOP);
    end

    // load_start coincident with a RUN fetch
    bus.fetch_addr = 4; bus.load_start = 1; cyc(); bus.load_start = 0;
    check("start+fetch word", bus.instruction, 32'h1000_0137);
    check("start+fetch cause", bus.fault_cause, 2'b00);
    cyc();
    check("after start cause", bus.fault_cause, 2'b11);
    bus.fetch_req = 0;

    // Restart mid-load with a byte in the same cycle
    send(8'h11, 0); send(8'h22, 0);
    bus.load_start = 1; send(8'hAA, 0); bus.load_start = 0;
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 1);
    bus.load_valid = 0; bus.load_last = 0;
    bus.fetch_req = 1; bus.fetch_addr = 0; cyc();
    check("restart word0", bus.instruction, 32'h8877_6655);
    bus.fetch_req = 0;

    // Truncated full-memory load, then an extra byte that must be refused
    bus.load_start = 1; cyc(); bus.load_start = 0;
    for (int i = 0; i < DEPTH; i++) send(8'(i) ^ 8'h5A, 1'b0);
    check("trunc set", bus.load_trunc, 1);
    check("trunc done", bus.load_done, 1);
    check("trunc ready", bus.load_ready, 0);
    send(8'hFF, 1'b1);
    bus.load_valid = 0; bus.load_last = 0;
    check("trunc sticky", bus.load_trunc, 1);
    check("extra ready", bus.load_ready, 0);
    bus.fetch_req = 1; bus.fetch_addr = 32'h3FC; cyc();
    check("trunc top word", bus.instruction, 32'hA5A4_A7A6);
    bus.fetch_addr = 0; cyc();
    check("trunc word0 intact", bus.instruction, 32'h5958_5B5A);
    bus.fetch_req = 0;

    // Full-memory load with load_last on the final byte
    bus.load_start = 1; cyc(); bus.load_start = 0;
    for (int i = 0; i < DEPTH; i++) send(8'(i), (i == DEPTH - 1));
    bus.load_valid = 0; bus.load_last = 0;
    check("full no trunc", bus.load_trunc, 0);
    check("full done", bus.load_done, 1);
    bus.fetch_req = 1; bus.fetch_addr = 32'h3FC; cyc();
    check("full top word", bus.instruction, 32'hFFFE_FDFC);
    bus.fetch_req = 0;

    // Asynchronous reset in the middle of a load
    bus.load_start = 1; cyc(); bus.load_start = 0;
    send(8'h12, 0);
    bus.load_valid = 0;
    bus.fetch_req = 1; bus.fetch_addr = 0; cyc();
    check("pre-rst busy", bus.busy, 1);
    check("pre-rst fetch_valid", bus.fetch_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async busy", bus.busy, 0);
    check("async ready", bus.load_ready, 0);
    check("async fetch_valid", bus.fetch_valid, 0);
    check("async instr", bus.instruction, NOP);
    #2 rst = 1'b0;
    cyc();
    check("post-rst cause", bus.fault_cause, 2'b11);
    bus.fetch_req = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
